// File: rtl/jpeg_pkg.sv
// Shared constants, state encodings and helpers for the JPEG encoder front end.
package jpeg_pkg;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    localparam int         BLOCK_BYTES    = 192;
    localparam int         ROWS_PER_BLOCK = 24;
    localparam logic [7:0] LEVEL_SHIFT    = 8'h80;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_FETCH = 2'd1,
        W_GAP   = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_WAIT = 1'b0,
        R_EMIT = 1'b1
    } rd_state_e;

    // One-hot byte-lane enable for a sample position within a row.
    function automatic logic [7:0] lane_mask(input logic [2:0] lane);
        return 8'b0000_0001 << lane;
    endfunction

endpackage

// File: rtl/je_bank_ram.sv
// Two-bank 48 x 64-bit simple dual-port RAM: byte-lane writes, registered read.
// Bank 1 occupies the upper 24 rows of the array.
module je_bank_ram
    import jpeg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en_i,
    input  logic        wr_bank_i,
    input  logic [4:0]  wr_row_i,
    input  logic [7:0]  wr_be_i,
    input  logic [63:0] wr_data_i,
    input  logic        rd_en_i,
    input  logic        rd_bank_i,
    input  logic [4:0]  rd_row_i,
    output logic [63:0] rd_data_o
);

    localparam int DEPTH = 2 * ROWS_PER_BLOCK;

    logic [5:0] wr_addr;
    logic [5:0] rd_addr;

    assign wr_addr = wr_bank_i ? 6'(wr_row_i) + 6'(ROWS_PER_BLOCK) : 6'(wr_row_i);
    assign rd_addr = rd_bank_i ? 6'(rd_row_i) + 6'(ROWS_PER_BLOCK) : 6'(rd_row_i);

    // One narrow array per lane keeps each byte enable a plain write enable.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : gen_lane
            logic [7:0] mem [0:DEPTH-1];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en_i && wr_be_i[gi]) begin
                    mem[wr_addr] <= wr_data_i[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_q <= '0;
                end else if (rd_en_i) begin
                    rd_q <= mem[rd_addr];
                end
            end

            assign rd_data_o[gi*8 +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/je_block_buffer.sv
// Fetches 192-byte YUV blocks, level-shifts them into a ping-pong buffer and
// re-emits each block as 24 rows of 8 signed samples over valid/ready.
module je_block_buffer
    import jpeg_pkg::*;
#(
    parameter int NUM_BLOCKS = 1200,
    parameter int RD_GAP     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    output logic        je_rd,
    input  logic [7:0]  je_data,
    output logic        row_valid,
    input  logic        row_ready,
    output logic [63:0] row_data,
    output logic [1:0]  row_comp,
    output logic [2:0]  row_idx,
    output logic        row_last,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [10:0] NUM_BLOCKS_W = 11'(NUM_BLOCKS);
    localparam logic [15:0] GAP_LAST     = (RD_GAP > 0) ? 16'(RD_GAP - 1) : 16'd0;
    localparam logic [7:0]  LAST_BYTE    = 8'(BLOCK_BYTES - 1);
    localparam logic [4:0]  LAST_ROW     = 5'(ROWS_PER_BLOCK - 1);

    wr_state_e   wr_state_q, wr_state_d;
    rd_state_e   rd_state_q, rd_state_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic        je_rd_q, je_rd_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        cap_valid_q;
    logic [7:0]  cap_idx_q;
    logic        wr_sel_q, wr_sel_d;
    logic        rd_sel_q, rd_sel_d;
    logic [1:0]  full_q, full_d;
    logic [10:0] fetched_q, fetched_d;
    logic [10:0] emitted_q, emitted_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [4:0]  row_q, row_d;
    logic        row_valid_q, row_valid_d;
    logic [1:0]  comp_q, comp_d;
    logic [2:0]  idx_q, idx_d;
    logic        last_q, last_d;

    logic        cap_last;
    logic        rd_en;
    logic        rd_bank;
    logic [4:0]  rd_row;
    logic [4:0]  row_next;
    logic [63:0] ram_rd_data;

    // The byte requested in cycle k arrives in cycle k+1 and is written then.
    assign cap_last = cap_valid_q && (cap_idx_q == LAST_BYTE);
    assign row_next = row_q + 5'd1;

    je_bank_ram u_ram (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (cap_valid_q),
        .wr_bank_i (wr_sel_q),
        .wr_row_i  (cap_idx_q[7:3]),
        .wr_be_i   (lane_mask(cap_idx_q[2:0])),
        .wr_data_i ({8{je_data ^ LEVEL_SHIFT}}),
        .rd_en_i   (rd_en),
        .rd_bank_i (rd_bank),
        .rd_row_i  (rd_row),
        .rd_data_o (ram_rd_data)
    );

    always_comb begin
        wr_state_d   = wr_state_q;
        rd_state_d   = rd_state_q;
        byte_cnt_d   = byte_cnt_q;
        je_rd_d      = je_rd_q;
        gap_cnt_d    = gap_cnt_q;
        wr_sel_d     = wr_sel_q;
        rd_sel_d     = rd_sel_q;
        full_d       = full_q;
        fetched_d    = fetched_q;
        emitted_d    = emitted_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        row_d        = row_q;
        row_valid_d  = row_valid_q;
        comp_d       = comp_q;
        idx_d        = idx_q;
        last_d       = last_q;
        rd_en        = 1'b0;
        rd_bank      = rd_sel_q;
        rd_row       = '0;

        case (wr_state_q)
            W_IDLE: begin
                if (frame_start && !busy_q) begin
                    busy_d    = 1'b1;
                    fetched_d = '0;
                    emitted_d = '0;
                    gap_cnt_d = '0;
                    if (!full_q[wr_sel_q]) begin
                        wr_state_d = W_FETCH;
                        je_rd_d    = 1'b1;
                        byte_cnt_d = '0;
                    end else begin
                        wr_state_d = W_GAP;
                    end
                end
            end
            W_FETCH: begin
                if (byte_cnt_q == LAST_BYTE) begin
                    wr_state_d = W_GAP;
                    je_rd_d    = 1'b0;
                    gap_cnt_d  = '0;
                end else begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                end
            end
            W_GAP: begin
                if (gap_cnt_q < GAP_LAST) begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
                // Wait for the final capture so fetched/wr_sel are up to date.
                if (!cap_valid_q && gap_cnt_q >= GAP_LAST) begin
                    if (fetched_q >= NUM_BLOCKS_W) begin
                        wr_state_d = W_IDLE;
                    end else if (!full_q[wr_sel_q]) begin
                        wr_state_d = W_FETCH;
                        je_rd_d    = 1'b1;
                        byte_cnt_d = '0;
                    end
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        if (cap_last) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
            fetched_d        = fetched_q + 11'd1;
        end

        case (rd_state_q)
            R_WAIT: begin
                if (full_q[rd_sel_q]) begin
                    rd_en       = 1'b1;
                    rd_bank     = rd_sel_q;
                    rd_state_d  = R_EMIT;
                    row_d       = '0;
                    row_valid_d = 1'b1;
                    comp_d      = COMP_Y;
                    idx_d       = '0;
                    last_d      = 1'b0;
                end
            end
            R_EMIT: begin
                if (row_ready) begin
                    if (row_q == LAST_ROW) begin
                        full_d[rd_sel_q] = 1'b0;
                        rd_sel_d         = ~rd_sel_q;
                        emitted_d        = emitted_q + 11'd1;
                        if (emitted_q + 11'd1 == NUM_BLOCKS_W) begin
                            frame_done_d = 1'b1;
                            busy_d       = 1'b0;
                        end
                        // Chain straight into the other bank to avoid a bubble.
                        if (full_q[~rd_sel_q]) begin
                            rd_en   = 1'b1;
                            rd_bank = ~rd_sel_q;
                            row_d   = '0;
                            comp_d  = COMP_Y;
                            idx_d   = '0;
                            last_d  = 1'b0;
                        end else begin
                            rd_state_d  = R_WAIT;
                            row_valid_d = 1'b0;
                            last_d      = 1'b0;
                        end
                    end else begin
                        rd_en  = 1'b1;
                        rd_row = row_next;
                        row_d  = row_next;
                        comp_d = 2'(row_next >> 3);
                        idx_d  = row_next[2:0];
                        last_d = (row_next == LAST_ROW);
                    end
                end
            end
            default: rd_state_d = R_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q   <= W_IDLE;
            rd_state_q   <= R_WAIT;
            byte_cnt_q   <= '0;
            je_rd_q      <= 1'b0;
            gap_cnt_q    <= '0;
            cap_valid_q  <= 1'b0;
            cap_idx_q    <= '0;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            full_q       <= '0;
            fetched_q    <= '0;
            emitted_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            row_q        <= '0;
            row_valid_q  <= 1'b0;
            comp_q       <= '0;
            idx_q        <= '0;
            last_q       <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            byte_cnt_q   <= byte_cnt_d;
            je_rd_q      <= je_rd_d;
            gap_cnt_q    <= gap_cnt_d;
            cap_valid_q  <= je_rd_q;
            cap_idx_q    <= byte_cnt_q;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            full_q       <= full_d;
            fetched_q    <= fetched_d;
            emitted_q    <= emitted_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            row_q        <= row_d;
            row_valid_q  <= row_valid_d;
            comp_q       <= comp_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
        end
    end

    assign je_rd      = je_rd_q;
    assign row_valid  = row_valid_q;
    assign row_data   = ram_rd_data;
    assign row_comp   = comp_q;
    assign row_idx    = idx_q;
    assign row_last   = last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_je_block_buffer.sv
// Randomised bench for je_block_buffer: a byte-source model feeds je_data and
// builds expected rows from the raw bytes; one negedge process checks outputs.
module tb_je_block_buffer;

    localparam int NB  = 4;
    localparam int GAP = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        je_rd;
    logic [7:0]  je_data = 8'h00;
    logic        row_valid;
    logic        row_ready = 1'b1;
    logic [63:0] row_data;
    logic [1:0]  row_comp;
    logic [2:0]  row_idx;
    logic        row_last;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    je_block_buffer #(.NUM_BLOCKS(NB), .RD_GAP(GAP)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .je_rd       (je_rd),
        .je_data     (je_data),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_data    (row_data),
        .row_comp    (row_comp),
        .row_idx     (row_idx),
        .row_last    (row_last),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  blk_bytes [192];
    int          blk_cnt = 0;
    int          frame_rd_cnt = 0;
    bit          pin_first = 1'b0;
    logic [63:0] exp_data_q [$];
    int          exp_row_q [$];

    always @(posedge clk) begin
        logic [7:0]  b;
        logic [63:0] rw;
        if (!reset && je_rd) begin
            if (pin_first && frame_rd_cnt < 192) b = 8'(frame_rd_cnt);
            else                                 b = 8'($urandom);
            je_data <= b;
            blk_bytes[blk_cnt] = b;
            blk_cnt++;
            frame_rd_cnt++;
            if (blk_cnt == 192) begin
                for (int r = 0; r < 24; r++) begin
                    for (int j = 0; j < 8; j++) rw[j*8 +: 8] = blk_bytes[r*8 + j] ^ 8'h80;
                    exp_data_q.push_back(rw);
                    exp_row_q.push_back(r);
                end
                blk_cnt = 0;
            end
        end
    end

    // ---------------- row_ready driver ----------------
    int ready_mode = 0;   // 0: always ready, 1: 30% ready, 2: never ready
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       row_ready = 1'b1;
            1:       row_ready = ($urandom_range(0, 99) < 30);
            default: row_ready = 1'b0;
        endcase
    end

    // ---------------- compare process ----------------
    bit          stalled_prev = 1'b0;
    logic [63:0] prev_data;
    logic [5:0]  prev_meta;
    bit          exp_done = 1'b0;
    int          blocks_done = 0;
    int          frame_rows = 0;
    int          done_cnt = 0;
    bit          rd_prev = 1'b0;
    bit          seen_high = 1'b0;
    int          low_run = 0;

    always @(negedge clk) begin
        logic [63:0] ed;
        int          er;
        if (reset) begin
            stalled_prev = 1'b0;
            exp_done     = 1'b0;
            seen_high    = 1'b0;
            rd_prev      = 1'b0;
            low_run      = 0;
        end else begin
            if (stalled_prev) begin
                check("hold_valid", 64'(row_valid), 64'd1);
                check("hold_data", row_data, prev_data);
                check("hold_meta", 64'({row_comp, row_idx, row_last}), 64'(prev_meta));
            end
            stalled_prev = row_valid && !row_ready;
            prev_data    = row_data;
            prev_meta    = {row_comp, row_idx, row_last};

            if (frame_done || exp_done) check("frame_done", 64'(frame_done), 64'(exp_done));
            if (frame_done) begin
                check("busy_at_done", 64'(busy), 64'd0);
                done_cnt++;
            end
            exp_done = 1'b0;

            if (row_valid && row_ready) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_row: got %h expected none", row_data);
                end else begin
                    ed = exp_data_q.pop_front();
                    er = exp_row_q.pop_front();
                    $display("row %0d: data=%h comp=%0d idx=%0d last=%0d", er, row_data, row_comp, row_idx, row_last);
                    check("row_data", row_data, ed);
                    check("row_meta", 64'({row_comp, row_idx, row_last}),
                          64'({2'(er / 8), 3'(er % 8), er == 23}));
                    if (pin_first && frame_rows == 0)
                        check("pin_row0", row_data, 64'h8786858483828180);
                    if (pin_first && frame_rows == 23) begin
                        check("pin_row23", row_data, 64'h3F3E3D3C3B3A3938);
                        check("pin_meta23", 64'({row_comp, row_idx, row_last}), 64'(6'b10_111_1));
                    end
                    frame_rows++;
                    if (er == 23) begin
                        blocks_done++;
                        if (blocks_done == NB) exp_done = 1'b1;
                    end
                end
            end

            if (je_rd) begin
                if (!rd_prev && seen_high) check("rd_gap_ok", 64'(low_run >= GAP), 64'd1);
                seen_high = 1'b1;
                low_run   = 0;
            end else begin
                low_run++;
            end
            rd_prev = je_rd;
        end
    end

    // ---------------- tasks ----------------
    task automatic prep_frame(input int mode, input bit pin);
        ready_mode   = mode;
        pin_first    = pin;
        frame_rd_cnt = 0;
        frame_rows   = 0;
        blocks_done  = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic start_frame();
        pulse_start();
        check("rd_first", 64'(je_rd), 64'd1);
        check("busy_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        int start_cnt = done_cnt;
        int n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_in_budget", 64'(done_cnt != start_cnt), 64'd1);
        @(negedge clk);
    endtask

    task automatic end_frame_checks();
        check("rd_total", 64'(frame_rd_cnt), 64'(192 * NB));
        check("rows_total", 64'(frame_rows), 64'(24 * NB));
        check("rows_left", 64'(exp_data_q.size()), 64'd0);
        check("busy_end", 64'(busy), 64'd0);
    endtask

    task automatic run_frame(input int mode, input bit pin);
        prep_frame(mode, pin);
        start_frame();
        wait_done(30000);
        end_frame_checks();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rd_snap;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_je_rd", 64'(je_rd), 64'd0);
        check("rst_valid", 64'(row_valid), 64'd0);
        check("rst_data", row_data, 64'd0);
        check("rst_meta", 64'({row_comp, row_idx, row_last}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Streaming with the pinned index pattern in block 0.
        run_frame(0, 1'b1);

        // Random back-pressure.
        run_frame(1, 1'b0);

        // Ping-pong full: reader stalled, both banks fill, writer stops.
        prep_frame(2, 1'b0);
        start_frame();
        repeat (1000) @(negedge clk);
        check("pp_rd_count", 64'(frame_rd_cnt), 64'd384);
        check("pp_rd_low", 64'(je_rd), 64'd0);
        check("pp_valid", 64'(row_valid), 64'd1);
        ready_mode = 0;
        wait_done(30000);
        end_frame_checks();

        // frame_start while busy must be ignored.
        prep_frame(1, 1'b0);
        start_frame();
        repeat (300) @(negedge clk);
        pulse_start();
        wait_done(30000);
        end_frame_checks();
        rd_snap = frame_rd_cnt;
        repeat (50) @(negedge clk);
        check("no_restart", 64'(frame_rd_cnt), 64'(rd_snap));

        // Reset in the middle of the first fetch.
        prep_frame(0, 1'b0);
        start_frame();
        n = 0;
        while (frame_rd_cnt < 100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached_byte100", 64'(frame_rd_cnt >= 100), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        blk_cnt = 0;
        exp_data_q.delete();
        exp_row_q.delete();
        check("mid_rst_je_rd", 64'(je_rd), 64'd0);
        check("mid_rst_valid", 64'(row_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        rd_snap = frame_rd_cnt;
        repeat (20) @(negedge clk);
        check("mid_rst_idle", 64'(frame_rd_cnt), 64'(rd_snap));

        // Clean frame after reset, pinned pattern again.
        run_frame(0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
